uart_rx_ascii: RTL and testbench
================================

Name: uart_rx_ascii

Overview:
- UART 8N1 serial receiver that feeds the `verify` sequence checker.
- Converts the incoming serial line into the byte stream `verify` consumes: `ascii_char` plus a one-cycle `char_valid` strobe.
- Sits between the board RX pin and `verify`, and runs at the same `freq` and bit rate the benches use (`UART_RX_BAUD`).
- The framing bytes 0x00 that surround each sequence are delivered as ordinary characters.

Parameters:
- `UART_RX_BAUD`, default 20: receive bit rate in bits per time unit.
- `freq`, default 200: clock frequency in the same units.
- `TR`: derived localparam = `freq/UART_RX_BAUD` clocks per bit. Default 10; must be >= 4.
- `HALF`: derived localparam = `TR/2`. Default 5.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous reset, active-high.
- `rx`  input  1  asynchronous serial line; idle high.
- `ascii_char`  output  8  last correctly received byte; held until the next one.
- `char_valid`  output  1  one-cycle pulse; `ascii_char` is new in the same cycle.
- `frame_error`  output  1  one-cycle pulse when the stop bit is sampled low.
- `rx_busy`  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- **Synchronizer:** `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions below use the synchronized value `rx_s`.
- **Reset values:** `ascii_char`=0x00, `char_valid`=0, `frame_error`=0, `rx_busy`=0, state=IDLE, bit counter=0, divider=0. Reset mid-frame discards the partial byte; no strobe is produced.
- **Bit order:** 8N1, LSB first. Shift register shifts right, new bit enters at bit 7.
- **Divider:** counts 0..`TR`-1 and wraps. Bit index counts 0..7. Let t0 be the first edge at which `rx_s`=0 while in IDLE.
- **IDLE:** `rx_s`=0 -> START, divider cleared.
- **START:** at t0+`HALF`, sample `rx_s`.
  - 0 -> DATA, divider cleared.
  - 1 -> glitch: return to IDLE, no strobe.
- **DATA:** bit i is sampled at t0+`HALF`+(i+1)·`TR`, for i=0..7. After bit 7 -> STOP.
- **STOP:** sample at t0+`HALF`+9·`TR`.
  - 1 -> on that edge `ascii_char` <= shift register and `char_valid`=1 for exactly that following cycle; next state IDLE. A new start bit is detectable from the next cycle.
  - 0 -> `frame_error`=1 for one cycle; `ascii_char` unchanged; `char_valid` stays 0; next state BREAK.
- **BREAK:** wait until `rx_s`=1, then IDLE. A line held low never produces extra strobes.
- **Timing:**
  - Latency from the `rx` pin falling edge to `char_valid` high: 2 + `HALF` + 9·`TR` + 1 clocks. Default = 98; exact, no jitter.
  - `char_valid` and `frame_error` are never high in the same cycle.
  - Minimum spacing between consecutive `char_valid` pulses is 10·`TR` - `HALF` clocks.
- **Value handling:** byte 0x00 with a valid stop bit is a normal character and pulses `char_valid`. No parity. No overrun condition: the output register is simply overwritten.

Test Plan:
- **Single byte:** after reset, send 0x28 ('(') at `TR`=10, pin falling edge at cycle C -> exactly one `char_valid` at C+98, `ascii_char`=0x28; `rx_busy` falls to 0 on the following cycle.
- **Back-to-back frames, zero idle gap:** send 0x00,'(','+','1','2',')',0x00 -> 7 pulses carrying 0x00,0x28,0x2B,0x31,0x32,0x29,0x00, spaced 100 clocks apart; `frame_error` never asserts.
- **Start glitch:** `rx` low for 3 clocks, then high -> no `char_valid`, no `frame_error`; `rx_busy` back to 0 within `HALF`+3 clocks; a following 0x41 is received correctly.
- **Framing error:** previous char 0x31, then send 0x41 with stop bit 0 and the line held low 50 clocks -> one `frame_error` pulse, no `char_valid`, `ascii_char` stays 0x31. Release the line and send 0x32 -> `char_valid` with 0x32.
- **Reset mid-frame:** assert `rst` for 1 clock during data bit 4 of 0x55 -> all outputs 0, no strobe for that byte; the next full frame 0x2B is received correctly.

Source files
------------

// File: rtl/uart_rx_ascii.sv
//------------------------------------------------------------------------------
// uart_rx_ascii
//
// UART 8N1 receiver that turns the serial RX line into a byte stream for the
// downstream sequence checker. Every correctly framed byte, including the
// 0x00 framing bytes, is presented on o_ascii_char with a one-cycle
// o_char_valid strobe.
//
// Parameters:
//   UART_RX_BAUD - receive bit rate (bits per time unit)
//   freq         - clock frequency (same time unit); freq/UART_RX_BAUD >= 4
//
// Ports:
//   i_clk         - system clock
//   i_rst         - synchronous reset, active-high
//   i_rx          - asynchronous serial line, idle high
//   o_ascii_char  - last correctly received byte, held until the next one
//   o_char_valid  - one-cycle pulse, o_ascii_char is new in the same cycle
//   o_frame_error - one-cycle pulse when the stop bit is sampled low
//   o_rx_busy     - high whenever the receiver is not idle
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_ascii #(
    parameter int unsigned UART_RX_BAUD = 20,
    parameter int unsigned freq         = 200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_ascii_char,
    output logic       o_char_valid,
    output logic       o_frame_error,
    output logic       o_rx_busy
);

    // Clocks per bit and half-bit offset used to land samples mid-bit.
    localparam int unsigned TR   = freq / UART_RX_BAUD;
    localparam int unsigned HALF = TR / 2;
    localparam int unsigned DivW = $clog2(TR);

    // Divider values at which a sample is taken (divider is cleared on entry).
    localparam logic [DivW-1:0] DivHalf = DivW'(HALF - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(TR - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [DivW-1:0] r_div;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_ascii;
    logic            r_valid;
    logic            r_ferr;
    logic            r_busy;

    logic            w_rx_s;

    assign w_rx_s = r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Synchronizer resets to the idle line level so reset never fakes a start bit.
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= StIdle;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ascii <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;

            // Strobes default low; set only on the deciding edge.
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (!w_rx_s) begin
                        r_state <= StStart;
                        r_div   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                StStart: begin
                    if (r_div == DivHalf) begin
                        r_div <= '0;
                        if (w_rx_s) begin
                            // Start bit did not survive to mid-bit: treat as a glitch.
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= StData;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                StData: begin
                    if (r_div == DivLast) begin
                        r_div   <= '0;
                        // LSB first: new bit enters at the top and shifts down.
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= StStop;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                StStop: begin
                    if (r_div == DivLast) begin
                        r_div <= '0;
                        if (w_rx_s) begin
                            r_ascii <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= StBreak;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                StBreak: begin
                    // A line held low must return high before another frame can start.
                    if (w_rx_s) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ascii_char  = r_ascii;
    assign o_char_valid  = r_valid;
    assign o_frame_error = r_ferr;
    assign o_rx_busy     = r_busy;

endmodule

// File: tb/tb_uart_rx_ascii.sv
//------------------------------------------------------------------------------
// tb_uart_rx_ascii
//
// Self-checking bench for uart_rx_ascii. Frames are driven bit by bit on the
// serial line; each complete frame pushes its expected outcome (strobe cycle,
// byte, good/error) into a queue, and a monitor matches every output strobe
// against that queue.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_ascii;

    localparam int unsigned BAUD = 20;
    localparam int unsigned FREQ = 200;
    localparam int          TR   = FREQ / BAUD;
    localparam int          HALF = TR / 2;
    // Pin falling edge to strobe: 2 sync flops, t0 edge, mid-start, 9 bits.
    localparam int          LAT  = 2 + HALF + 9 * TR + 1;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_rx;
    logic [7:0] o_ascii_char;
    logic       o_char_valid;
    logic       o_frame_error;
    logic       o_rx_busy;

    uart_rx_ascii #(
        .UART_RX_BAUD(BAUD),
        .freq        (FREQ)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .o_ascii_char (o_ascii_char),
        .o_char_valid (o_char_valid),
        .o_frame_error(o_frame_error),
        .o_rx_busy    (o_rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       is_err;
    } evt_t;

    evt_t       exp_q[$];
    logic [7:0] model_ascii = 8'h00;
    int         n_checks    = 0;
    int         n_fail      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Match every strobe against the expected-event queue.
    always @(negedge clk) begin : monitor
        evt_t e;
        if (o_char_valid || o_frame_error) begin
            check_eq("strobe_overlap", {31'd0, o_char_valid & o_frame_error}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("spurious_strobe", {30'd0, o_char_valid, o_frame_error}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("strobe_cycle", cyc, e.at);
                check_eq("strobe_kind", {31'd0, o_frame_error}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    check_eq("char", {24'd0, o_ascii_char}, {24'd0, e.data});
                    model_ascii = e.data;
                end else begin
                    check_eq("char_hold", {24'd0, o_ascii_char}, {24'd0, model_ascii});
                end
            end
        end
    end

    // Drive one frame starting at the current negedge; stop=0 holds the line low.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int low_hold);
        evt_t e;
        e.at     = cyc + LAT;
        e.data   = b;
        e.is_err = ~stop;
        exp_q.push_back(e);
        i_rx = 1'b0;
        repeat (TR) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (TR) @(negedge clk);
        end
        if (stop) begin
            i_rx = 1'b1;
            repeat (TR) @(negedge clk);
        end else begin
            i_rx = 1'b0;
            repeat (low_hold) @(negedge clk);
            i_rx = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq(tag, exp_q.size(), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] seq [7];
        logic [7:0] rb;
        logic       rstop;
        logic       prev_err;

        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (4) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check_eq("rst_char", {24'd0, o_ascii_char}, 32'd0);
        check_eq("rst_valid", {31'd0, o_char_valid}, 32'd0);
        check_eq("rst_ferr", {31'd0, o_frame_error}, 32'd0);
        check_eq("rst_busy", {31'd0, o_rx_busy}, 32'd0);

        // Single byte with busy observed around the strobe.
        idle(10);
        fork
            send_frame(8'h28, 1'b1, 0);
            begin
                repeat (LAT - 1) @(negedge clk);
                check_eq("single_busy_before", {31'd0, o_rx_busy}, 32'd1);
                repeat (2) @(negedge clk);
                check_eq("single_busy_after", {31'd0, o_rx_busy}, 32'd0);
            end
        join
        wait_drain("single_drain");

        // Back-to-back frames, zero idle gap.
        idle(20);
        seq = '{8'h00, 8'h28, 8'h2B, 8'h31, 8'h32, 8'h29, 8'h00};
        for (int i = 0; i < 7; i++) send_frame(seq[i], 1'b1, 0);
        wait_drain("b2b_drain");

        // Start glitch.
        idle(20);
        i_rx = 1'b0;
        repeat (3) @(negedge clk);
        i_rx = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("glitch_busy_high", {31'd0, o_rx_busy}, 32'd1);
        repeat (HALF + 1) @(negedge clk);
        check_eq("glitch_busy_low", {31'd0, o_rx_busy}, 32'd0);
        idle(20);
        send_frame(8'h41, 1'b1, 0);
        wait_drain("glitch_drain");

        // Framing error with the line held low, then recovery.
        idle(20);
        send_frame(8'h31, 1'b1, 0);
        send_frame(8'h41, 1'b0, 50);
        check_eq("ferr_char_hold", {24'd0, o_ascii_char}, 32'h31);
        idle(5);
        send_frame(8'h32, 1'b1, 0);
        wait_drain("ferr_drain");

        // Reset during data bit 4 of 0x55; transmitter aborts the frame.
        idle(20);
        rb   = 8'h55;
        i_rx = 1'b0;
        repeat (TR) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            i_rx = rb[i];
            repeat (TR) @(negedge clk);
        end
        i_rx = rb[4];
        repeat (HALF) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst       = 1'b0;
        model_ascii = 8'h00;
        @(negedge clk);
        check_eq("midrst_char", {24'd0, o_ascii_char}, 32'd0);
        check_eq("midrst_valid", {31'd0, o_char_valid}, 32'd0);
        check_eq("midrst_ferr", {31'd0, o_frame_error}, 32'd0);
        check_eq("midrst_busy", {31'd0, o_rx_busy}, 32'd0);
        idle(200);
        send_frame(8'h2B, 1'b1, 0);
        wait_drain("midrst_drain");

        // Randomized traffic with occasional framing errors.
        idle(20);
        prev_err = 1'b0;
        for (int n = 0; n < 30; n++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 99) >= 15);
            send_frame(rb, rstop, TR + int'($urandom_range(0, 30)));
            prev_err = ~rstop;
            idle(prev_err ? int'($urandom_range(2, 20)) : int'($urandom_range(0, 20)));
        end
        wait_drain("random_drain");
        check_eq("final_busy", {31'd0, o_rx_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
